// File: rtl/vend_ctrl.sv
// vend_ctrl -- vending machine purchase controller.
//
// Restocks/prices item slots held in an external synchronous item memory,
// runs one purchase at a time (select, read slot, collect coins, vend,
// return change) and reports sold-out / cancelled outcomes.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   cfg_valid/addr/price/count  restock write request; cfg_ready high in IDLE
//   sel_valid, sel_addr         purchase request (sampled in IDLE only)
//   coin_valid, coin_value      single-cycle coin strobe and its value
//   cancel                      abort the purchase (honoured while collecting)
//   mem_we/waddr/wprice/wcount  item memory write port
//   mem_raddr, mem_rprice/count item memory read port (data one clk after addr)
//   dispense, dispense_addr     one-cycle vend pulse and slot vended
//   change_valid, change_amt    one-cycle change/refund pulse and amount
//   busy                        high in every state except IDLE
//   err                         0 none, 1 sold out, 2 cancelled
module vend_ctrl #(
  parameter int MAX_ITEMS = 1024,
  parameter int AW        = $clog2(MAX_ITEMS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  input  logic [AW-1:0] cfg_addr,
  input  logic [15:0]   cfg_price,
  input  logic [7:0]    cfg_count,
  output logic          cfg_ready,
  input  logic          sel_valid,
  input  logic [AW-1:0] sel_addr,
  input  logic          coin_valid,
  input  logic [15:0]   coin_value,
  input  logic          cancel,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [15:0]   mem_wprice,
  output logic [7:0]    mem_wcount,
  output logic [AW-1:0] mem_raddr,
  input  logic [15:0]   mem_rprice,
  input  logic [7:0]    mem_rcount,
  output logic          dispense,
  output logic [AW-1:0] dispense_addr,
  output logic          change_valid,
  output logic [15:0]   change_amt,
  output logic          busy,
  output logic [1:0]    err
);

  typedef enum logic [2:0] {
    IDLE, RD, WT, CHK, COLLECT, VEND, CHANGE
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] slot_q, slot_next;
  logic [15:0]   price_q, price_next;
  logic [7:0]    count_q, count_next;
  logic [15:0]   credit, credit_next;
  logic [15:0]   change_due, change_next;
  logic [1:0]    err_next;

  // Saturating credit accumulation: the carry out selects 16'hFFFF.
  logic [16:0]   credit_sum;
  logic [15:0]   credit_sat;
  assign credit_sum = {1'b0, credit} + {1'b0, coin_value};
  assign credit_sat = credit_sum[16] ? 16'hFFFF : credit_sum[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      slot_q     <= '0;
      price_q    <= '0;
      count_q    <= '0;
      credit     <= '0;
      change_due <= '0;
      err        <= '0;
    end else begin
      state      <= state_next;
      slot_q     <= slot_next;
      price_q    <= price_next;
      count_q    <= count_next;
      credit     <= credit_next;
      change_due <= change_next;
      err        <= err_next;
    end
  end

  always_comb begin
    state_next    = state;
    slot_next     = slot_q;
    price_next    = price_q;
    count_next    = count_q;
    credit_next   = credit;
    change_next   = change_due;
    err_next      = err;
    cfg_ready     = 1'b0;
    busy          = 1'b1;
    mem_we        = 1'b0;
    mem_waddr     = '0;
    mem_wprice    = '0;
    mem_wcount    = '0;
    mem_raddr     = slot_q;
    dispense      = 1'b0;
    dispense_addr = '0;
    change_valid  = 1'b0;
    change_amt    = '0;

    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        mem_raddr = '0;
        if (cfg_valid) begin
          // Pass-through write is suppressed while reset is held so that
          // every output except cfg_ready reads 0 during reset.
          if (!rst) begin
            mem_we     = 1'b1;
            mem_waddr  = cfg_addr;
            mem_wprice = cfg_price;
            mem_wcount = cfg_count;
          end
        end else if (sel_valid) begin
          slot_next   = sel_addr;
          credit_next = '0;
          err_next    = 2'd0;
          state_next  = RD;
        end
      end
      RD:  state_next = WT;
      WT:  state_next = CHK;
      CHK: begin
        price_next = mem_rprice;
        count_next = mem_rcount;
        if (mem_rcount == 8'd0) begin
          err_next   = 2'd1;
          state_next = IDLE;
        end else begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          // A coin arriving with cancel is not credited.
          err_next    = 2'd2;
          change_next = credit;
          state_next  = CHANGE;
        end else begin
          if (coin_valid) credit_next = credit_sat;
          // Registered credit is compared, so the coin that reaches the
          // price is accumulated one cycle before leaving for VEND.
          if (credit >= price_q) state_next = VEND;
        end
      end
      VEND: begin
        dispense      = 1'b1;
        dispense_addr = slot_q;
        mem_we        = 1'b1;
        mem_waddr     = slot_q;
        mem_wprice    = price_q;
        mem_wcount    = count_q - 8'd1;
        change_next   = credit - price_q;
        state_next    = CHANGE;
      end
      CHANGE: begin
        if (change_due != 16'd0) begin
          change_valid = 1'b1;
          change_amt   = change_due;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl -- self-checking bench for vend_ctrl with a synchronous item
// memory model and a transaction-level purchase reference model.
module tb_vend_ctrl;
  localparam int MAX_ITEMS = 16;
  localparam int AW        = 4;

  logic          clk, rst;
  logic          cfg_valid;
  logic [AW-1:0] cfg_addr;
  logic [15:0]   cfg_price;
  logic [7:0]    cfg_count;
  logic          cfg_ready;
  logic          sel_valid;
  logic [AW-1:0] sel_addr;
  logic          coin_valid;
  logic [15:0]   coin_value;
  logic          cancel;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wprice;
  logic [7:0]    mem_wcount;
  logic [AW-1:0] mem_raddr;
  logic [15:0]   mem_rprice;
  logic [7:0]    mem_rcount;
  logic          dispense;
  logic [AW-1:0] dispense_addr;
  logic          change_valid;
  logic [15:0]   change_amt;
  logic          busy;
  logic [1:0]    err;

  vend_ctrl #(.MAX_ITEMS(MAX_ITEMS)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_price(cfg_price),
    .cfg_count(cfg_count), .cfg_ready(cfg_ready),
    .sel_valid(sel_valid), .sel_addr(sel_addr),
    .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wprice(mem_wprice),
    .mem_wcount(mem_wcount), .mem_raddr(mem_raddr),
    .mem_rprice(mem_rprice), .mem_rcount(mem_rcount),
    .dispense(dispense), .dispense_addr(dispense_addr),
    .change_valid(change_valid), .change_amt(change_amt),
    .busy(busy), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Item memory: synchronous write, registered read.
  logic [15:0] mem_price [MAX_ITEMS];
  logic [7:0]  mem_count [MAX_ITEMS];
  always @(posedge clk) begin
    if (mem_we) begin
      mem_price[mem_waddr] <= mem_wprice;
      mem_count[mem_waddr] <= mem_wcount;
    end
    mem_rprice <= mem_price[mem_raddr];
    mem_rcount <= mem_count[mem_raddr];
  end

  // Event monitor: accumulates what the DUT emitted.
  int disp_n = 0, disp_addr = 0;
  int vw_n = 0, vw_addr = 0, vw_price = 0, vw_count = 0;
  int chg_n = 0, chg_amt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (dispense) begin
        disp_n++;
        disp_addr = int'(dispense_addr);
      end
      if (mem_we && busy) begin
        vw_n++;
        vw_addr  = int'(mem_waddr);
        vw_price = int'(mem_wprice);
        vw_count = int'(mem_wcount);
      end
      if (change_valid) begin
        chg_n++;
        chg_amt = int'(change_amt);
      end
    end
  end

  // Reference model of slot contents.
  int ref_price [MAX_ITEMS];
  int ref_count [MAX_ITEMS];
  logic [15:0] coin_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_add(input int a, input int b);
    int s;
    s = a + b;
    return (s > 65535) ? 65535 : s;
  endfunction

  task automatic do_cfg(input int slot, input int price, input int count);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_addr  = AW'(slot);
    cfg_price = 16'(price);
    cfg_count = 8'(count);
    #1;
    check("cfg_we",    32'(mem_we), 1);
    check("cfg_waddr", 32'(mem_waddr), 32'(slot));
    check("cfg_wprice", 32'(mem_wprice), 32'(price));
    check("cfg_wcount", 32'(mem_wcount), 32'(count));
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    ref_price[slot] = price;
    ref_count[slot] = count;
    $display("[TB] cfg slot %0d price %0d count %0d", slot, price, count);
  endtask

  // Runs one purchase using coins from coin_q; cancel_at = coin index at which
  // to cancel (-1 = never). Expected outcome derives from the slot model.
  task automatic purchase(input int slot, input int cancel_at);
    int d0, v0, c0, credit, price, exp_err, exp_chg, exp_disp, i;
    bit done;
    d0 = disp_n; v0 = vw_n; c0 = chg_n;
    price = ref_price[slot];
    credit = 0; i = 0; done = 0;
    exp_err = 0; exp_chg = 0; exp_disp = 0;
    @(negedge clk);
    sel_valid = 1'b1;
    sel_addr  = AW'(slot);
    @(posedge clk);
    #1 sel_valid = 1'b0;
    // Read latency cycles: stray coins, cancels and selects must be ignored.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("rd_raddr", 32'(mem_raddr), 32'(slot));
        check("rd_err_clr", 32'(err), 0);
        check("rd_busy", 32'(busy), 1);
      end
      coin_valid = 1'($urandom_range(1));
      coin_value = 16'($urandom);
      cancel     = ($urandom_range(2) == 0);
      sel_valid  = 1'($urandom_range(1));
      sel_addr   = AW'($urandom_range(MAX_ITEMS - 1));
      @(posedge clk);
      #1 begin coin_valid = 1'b0; cancel = 1'b0; sel_valid = 1'b0; end
    end
    if (ref_count[slot] == 0) begin
      @(negedge clk);
      check("soldout_err", 32'(err), 1);
      check("soldout_busy", 32'(busy), 0);
      check("soldout_disp", 32'(disp_n - d0), 0);
      check("soldout_we", 32'(vw_n - v0), 0);
      $display("[TB] purchase slot %0d sold out", slot);
      return;
    end
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (credit >= price) begin
        // Last collect cycle; a coin here is still credited.
        if (i < coin_q.size()) begin
          coin_valid = 1'b1;
          coin_value = coin_q[i];
          credit = sat_add(credit, int'(coin_q[i]));
          i++;
        end
        exp_disp = 1; exp_err = 0; exp_chg = credit - price;
        @(posedge clk);
        #1 coin_valid = 1'b0;
        done = 1;
      end else if (i == cancel_at || i >= coin_q.size() || cyc >= 50) begin
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_value = (i < coin_q.size()) ? coin_q[i] : 16'($urandom);
        exp_disp = 0; exp_err = 2; exp_chg = credit;
        @(posedge clk);
        #1 begin cancel = 1'b0; coin_valid = 1'b0; end
        done = 1;
      end else if ($urandom_range(3) == 0) begin
        @(posedge clk);
      end else begin
        coin_valid = 1'b1;
        coin_value = coin_q[i];
        credit = sat_add(credit, int'(coin_q[i]));
        i++;
        @(posedge clk);
        #1 coin_valid = 1'b0;
      end
    end
    check("collect_done", 32'(done), 1);
    if (exp_disp == 1) begin
      @(negedge clk);
      check("vend_pulse", 32'(dispense), 1);
      check("vend_addr", 32'(dispense_addr), 32'(slot));
    end
    @(negedge clk);
    check("chg_pulse", 32'(change_valid), 32'(exp_chg != 0));
    @(negedge clk);
    check("end_busy", 32'(busy), 0);
    check("end_err", 32'(err), 32'(exp_err));
    check("disp_cnt", 32'(disp_n - d0), 32'(exp_disp));
    check("vw_cnt", 32'(vw_n - v0), 32'(exp_disp));
    check("chg_cnt", 32'(chg_n - c0), 32'(exp_chg != 0));
    if (exp_chg != 0) check("chg_amt", 32'(chg_amt), 32'(exp_chg));
    if (exp_disp == 1) begin
      check("disp_addr", 32'(disp_addr), 32'(slot));
      check("vw_addr", 32'(vw_addr), 32'(slot));
      check("vw_price", 32'(vw_price), 32'(price));
      check("vw_count", 32'(vw_count), 32'(ref_count[slot] - 1));
      ref_count[slot] = ref_count[slot] - 1;
    end
    $display("[TB] purchase slot %0d price %0d credit %0d vend %0d change %0d err %0d",
             slot, price, credit, exp_disp, exp_chg, exp_err);
  endtask

  initial begin
    int d0, v0, c0;
    for (int s = 0; s < MAX_ITEMS; s++) begin
      mem_price[s] = '0; mem_count[s] = '0;
      ref_price[s] = 0;  ref_count[s] = 0;
    end
    rst = 1'b1;
    cfg_valid = 1'b1; cfg_addr = '0; cfg_price = 16'd7; cfg_count = 8'd9;
    sel_valid = 1'b0; sel_addr = '0;
    coin_valid = 1'b0; coin_value = '0; cancel = 1'b0;
    #12;
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_raddr", 32'(mem_raddr), 0);
    check("rst_err", 32'(err), 0);
    check("rst_disp", 32'(dispense), 0);
    check("rst_chg", 32'(change_valid), 0);
    cfg_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Basic vend with change.
    do_cfg(5, 150, 2);
    coin_q = '{16'd100, 16'd100};
    purchase(5, -1);

    // Sold-out slot.
    do_cfg(3, 40, 0);
    coin_q = '{};
    purchase(3, -1);

    // Cancel with a simultaneous coin.
    coin_q = '{16'd100, 16'd50};
    purchase(5, 1);

    // cfg and sel together: cfg wins.
    @(negedge clk);
    cfg_valid = 1'b1; cfg_addr = AW'(9); cfg_price = 16'd20; cfg_count = 8'd4;
    sel_valid = 1'b1; sel_addr = AW'(5);
    #1;
    check("both_we", 32'(mem_we), 1);
    check("both_waddr", 32'(mem_waddr), 9);
    @(posedge clk);
    #1 begin cfg_valid = 1'b0; sel_valid = 1'b0; end
    ref_price[9] = 20; ref_count[9] = 4;
    @(negedge clk);
    check("both_busy", 32'(busy), 0);
    $display("[TB] cfg+sel together slot 9");

    // Saturating credit.
    do_cfg(11, 16'hFFF0, 1);
    coin_q = '{16'hFFFF, 16'h0010};
    purchase(11, -1);

    // Zero price vends immediately.
    do_cfg(12, 0, 3);
    coin_q = '{};
    purchase(12, -1);

    // Reset mid-collect with credit 80.
    do_cfg(7, 200, 3);
    d0 = disp_n; v0 = vw_n; c0 = chg_n;
    @(negedge clk);
    sel_valid = 1'b1; sel_addr = AW'(7);
    @(posedge clk);
    #1 sel_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    coin_valid = 1'b1; coin_value = 16'd80;
    @(posedge clk);
    #1 coin_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_ready", 32'(cfg_ready), 1);
    check("arst_raddr", 32'(mem_raddr), 0);
    check("arst_err", 32'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_idle", 32'(busy), 0);
    check("arst_disp", 32'(disp_n - d0), 0);
    check("arst_vw", 32'(vw_n - v0), 0);
    check("arst_chg", 32'(chg_n - c0), 0);
    $display("[TB] reset during collect slot 7");

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int slot;
      slot = $urandom_range(MAX_ITEMS - 1);
      if ($urandom_range(3) == 0) begin
        do_cfg(slot, $urandom_range(300), $urandom_range(3));
      end else begin
        int n;
        coin_q = '{};
        n = $urandom_range(6);
        for (int c = 0; c < n; c++) begin
          case ($urandom_range(4))
            0: coin_q.push_back(16'd5);
            1: coin_q.push_back(16'd25);
            2: coin_q.push_back(16'd50);
            3: coin_q.push_back(16'd100);
            default: coin_q.push_back(16'($urandom));
          endcase
        end
        purchase(slot, ($urandom_range(4) == 0) ? int'($urandom_range(n)) : -1);
      end
    end

    // Final memory contents against the slot model.
    repeat (2) @(negedge clk);
    for (int s = 0; s < MAX_ITEMS; s++) begin
      check("mem_count", 32'(mem_count[s]), 32'(ref_count[s]));
      check("mem_price", 32'(mem_price[s]), 32'(ref_price[s]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_ITEMS, default 1024, giving the number of item slots.
REQ-002 The block SHALL have derived parameter AW = $clog2(MAX_ITEMS), giving the item address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port cfg_valid, input, 1 bit: restock/price write request.
REQ-006 The block SHALL have port cfg_addr, input, AW bits: slot to write.
REQ-007 The block SHALL have port cfg_price, input, 16 bits: new slot price.
REQ-008 The block SHALL have port cfg_count, input, 8 bits: new slot count.
REQ-009 The block SHALL have port cfg_ready, output, 1 bit: high in IDLE; cfg is accepted when cfg_valid and cfg_ready are both high.
REQ-010 The block SHALL have port sel_valid, input, 1 bit: purchase request, sampled in IDLE only.
REQ-011 The block SHALL have port sel_addr, input, AW bits: selected slot.
REQ-012 The block SHALL have port coin_valid, input, 1 bit: single-cycle coin strobe.
REQ-013 The block SHALL have port coin_value, input, 16 bits: coin value.
REQ-014 The block SHALL have port cancel, input, 1 bit: abort the purchase.
REQ-015 The block SHALL have port mem_we, output, 1 bit: item memory write enable.
REQ-016 The block SHALL have port mem_waddr, output, AW bits: item memory write address.
REQ-017 The block SHALL have ports mem_wprice, output, 16 bits, and mem_wcount, output, 8 bits: item memory write data.
REQ-018 The block SHALL have port mem_raddr, output, AW bits: item memory read address.
REQ-019 The block SHALL have ports mem_rprice, input, 16 bits, and mem_rcount, input, 8 bits: read data, valid one clk after mem_raddr is presented.
REQ-020 The block SHALL have port dispense, output, 1 bit, plus dispense_addr, output, AW bits: one-cycle vend pulse and the slot vended.
REQ-021 The block SHALL have port change_valid, output, 1 bit, plus change_amt, output, 16 bits: one-cycle refund/change pulse and its amount.
REQ-022 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-023 The block SHALL have port err, output, 2 bits: 0 = none, 1 = sold out, 2 = cancelled; held until the next sel accept.

Function
REQ-024 The FSM SHALL have states IDLE, RD, WT, CHK, COLLECT, VEND, CHANGE.
REQ-025 In IDLE with cfg_valid high, the block SHALL drive mem_we=1, mem_waddr=cfg_addr, mem_wprice=cfg_price and mem_wcount=cfg_count in the same cycle (combinational pass-through), and remain in IDLE.
REQ-026 In IDLE, cfg_valid SHALL take priority over sel_valid when both are high in the same cycle; sel is then ignored.
REQ-027 In IDLE with sel_valid high and cfg_valid low, the block SHALL latch sel_addr into slot_q, clear credit and err, and go to RD.
REQ-028 In RD, the block SHALL drive mem_raddr=slot_q and go to WT.
REQ-029 In WT, the block SHALL hold mem_raddr=slot_q and go to CHK.
REQ-030 In CHK, the block SHALL latch mem_rprice/mem_rcount into price_q/count_q; if mem_rcount==0 it SHALL set err=1 and return to IDLE with no dispense; otherwise it SHALL go to COLLECT.
REQ-031 In COLLECT, each coin_valid SHALL add coin_value to a 16-bit credit register saturating at 16'hFFFF.
REQ-032 COLLECT SHALL go to VEND on the cycle after credit >= price_q, so a coin that reaches the price is counted first.
REQ-033 A price_q of 0 SHALL go to VEND on the first COLLECT cycle.
REQ-034 cancel in COLLECT SHALL set err=2, set change_due=credit and go to CHANGE.
REQ-035 cancel SHALL outrank coin_valid in the same cycle; that coin is not credited.
REQ-036 cancel outside COLLECT SHALL be ignored.
REQ-037 In VEND, for one cycle, the block SHALL drive dispense=1, dispense_addr=slot_q, mem_we=1, mem_waddr=slot_q, mem_wprice=price_q and mem_wcount=count_q-1.
REQ-038 VEND SHALL set change_due=credit-price_q and go to CHANGE.
REQ-039 In CHANGE, if change_due != 0 the block SHALL pulse change_valid=1 with change_amt=change_due for one cycle; the block SHALL go to IDLE regardless.
REQ-040 coin_valid outside COLLECT SHALL be dropped with no credit.
REQ-041 sel_valid while busy SHALL be ignored.
REQ-042 mem_raddr SHALL equal slot_q in all states except IDLE, and 0 in IDLE.
REQ-043 mem_we SHALL be 0 except in the cases of REQ-025 and REQ-037.

Reset
REQ-044 On rst high, immediately and independent of clk, the block SHALL go to IDLE and clear credit, change_due, slot_q, price_q, count_q and err to 0.
REQ-045 On rst high, all outputs SHALL be 0 except cfg_ready, which is 1.
REQ-046 Reset mid-purchase SHALL drop the credit, with no dispense, no change pulse and no memory write.

Verification
REQ-047 The bench SHALL cover: cfg slot 5 price 150 count 2; sel 5; coins 100,100 -> dispense with addr 5; write of count 1 to slot 5; change_amt=50; busy low after.
REQ-048 The bench SHALL cover: slot 3 count 0; sel 3 -> err=1 four cycles after sel accept; no dispense; no mem_we; return to IDLE.
REQ-049 The bench SHALL cover: sel slot 5, coin 100, then cancel and coin 50 in the same cycle -> change_amt=100; err=2; no dispense.
REQ-050 The bench SHALL cover: cfg and sel together in IDLE -> only the cfg write occurs; busy stays 0.
REQ-051 The bench SHALL cover: price 16'hFFF0; coins 16'hFFFF and 16'h0010 -> credit saturates at 16'hFFFF; dispense; change_amt=16'h000F.
REQ-052 The bench SHALL cover: rst asserted in COLLECT with credit 80 -> outputs zero before the next clk edge; no change pulse; IDLE after reset release.
